logic_bist: RTL and testbench

LOGIC_BIST -- requirements
Module: logic_bist

---
 rtl/logic_bist_pkg.sv | 33 +++
 rtl/logic_bist_lfsr16.sv | 22 ++
 rtl/logic_bist.sv | 168 ++++++++++++++++
 tb/tb_logic_bist.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_bist_pkg.sv
// Shared types and constants for the logic BIST controller: FSM states, opcodes, LFSR taps.
package logic_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_NAND = 3;

  // x^16 + x^14 + x^13 + x^11 + 1 for a left-shifting Fibonacci register: bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] op_eval(input int unsigned op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_bist_lfsr16.sv
// 16-bit Fibonacci LFSR with seed reload and single-step enable; left shift, feedback into bit 0.
module bist_lfsr16 import logic_bist_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/logic_bist.sv
// Logic BIST controller: drives LFSR operands into a logic unit and tallies pass/fail results.
// Optional first-failure capture ports are enabled by defining LOGIC_BIST_ERR_CAPTURE_EN.
module logic_bist import logic_bist_pkg::*; #(
  parameter int unsigned N        = 4,
  parameter int unsigned OPCODE   = 1,
  parameter int unsigned NUM_VEC  = 100,
  parameter int unsigned WAIT_CYC = 1,
  parameter logic [15:0] SEED0    = 16'hACE1,
  parameter logic [15:0] SEED1    = 16'h1D2C
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] in0,
  output logic [N-1:0] in1,
  input  logic [N-1:0] dut_out,
  output logic [15:0]  pass_cnt,
  output logic [15:0]  fail_cnt,
  output logic         all_pass
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
  ,
  output logic         ff_valid,
  output logic [N-1:0] ff_in0,
  output logic [N-1:0] ff_in1,
  output logic [N-1:0] ff_out
`endif
);

  localparam logic [15:0] NumVec  = 16'(NUM_VEC);
  localparam logic [3:0]  WaitCyc = 4'(WAIT_CYC);

  state_e      state_q;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  wait_cnt_q;
  logic [15:0] lfsr0, lfsr1;
  logic [15:0] op_full;
  logic [N-1:0] expected;
  logic        start_acc, step, match;
  logic [15:0] pass_d, fail_d;
  logic        unused_bits;

  bist_lfsr16 #(
    .SEED (SEED0)
  ) u_lfsr0 (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .step  (step),
    .state (lfsr0)
  );

  bist_lfsr16 #(
    .SEED (SEED1)
  ) u_lfsr1 (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .step  (step),
    .state (lfsr1)
  );

  // Operands come straight from the LFSRs, which only move at the end of CHECK.
  assign in0 = lfsr0[N-1:0];
  assign in1 = lfsr1[N-1:0];
  assign unused_bits = ^{lfsr0, lfsr1, op_full};

  always_comb begin
    start_acc = start && ((state_q == StIdle) || (state_q == StDone));
    step      = (state_q == StCheck);
    op_full   = op_eval(OPCODE, lfsr0, lfsr1);
    expected  = op_full[N-1:0];
    match     = (dut_out == expected);
    pass_d    = (match && (pass_cnt != 16'hFFFF)) ? pass_cnt + 16'd1 : pass_cnt;
    fail_d    = (!match && (fail_cnt != 16'hFFFF)) ? fail_cnt + 16'd1 : fail_cnt;
    idx_d     = idx_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      all_pass   <= 1'b0;
      pass_cnt   <= 16'd0;
      fail_cnt   <= 16'd0;
      idx_q      <= 16'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            pass_cnt <= 16'd0;
            fail_cnt <= 16'd0;
            idx_q    <= 16'd0;
            if (NumVec == 16'd0) begin
              state_q  <= StDone;
              busy     <= 1'b0;
              done     <= 1'b1;
              all_pass <= 1'b1;
            end else begin
              state_q  <= StDrive;
              busy     <= 1'b1;
              done     <= 1'b0;
              all_pass <= 1'b0;
            end
          end
        end
        StDrive: begin
          if (WaitCyc != 4'd0) begin
            state_q    <= StWait;
            wait_cnt_q <= WaitCyc - 4'd1;
          end else begin
            state_q <= StCheck;
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= StCheck;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        StCheck: begin
          pass_cnt <= pass_d;
          fail_cnt <= fail_d;
          idx_q    <= idx_d;
          if (idx_d == NumVec) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= (fail_d == 16'd0);
          end else begin
            state_q <= StDrive;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOGIC_BIST_ERR_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_valid <= 1'b0;
      ff_in0   <= '0;
      ff_in1   <= '0;
      ff_out   <= '0;
    end else if (start_acc) begin
      ff_valid <= 1'b0;
      ff_in0   <= '0;
      ff_in1   <= '0;
      ff_out   <= '0;
    end else if ((state_q == StCheck) && !match && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_in0   <= in0;
      ff_in1   <= in1;
      ff_out   <= dut_out;
    end
  end
`endif

endmodule

// File: tb/tb_logic_bist.sv
// Self-checking bench for logic_bist: randomized fault injection against an operand-sequence model.
module tb_logic_bist;

  localparam int NV  = 100;
  localparam int WC  = 1;
  localparam int XNV = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance: default parameters, OR unit with selectable fault behaviour.
  logic        start = 1'b0;
  logic        busy, done, all_pass;
  logic [3:0]  in0, in1, dut_out;
  logic [15:0] pass_cnt, fail_cnt;
  int          mode = 0;
  logic [3:0]  corrupt_tbl [256];

  always_comb begin
    case (mode)
      1:       dut_out = (in0 | in1) ^ corrupt_tbl[{in0, in1}];
      2:       dut_out = (in0 | in1) & 4'b1110;
      default: dut_out = in0 | in1;
    endcase
  end

`ifdef LOGIC_BIST_ERR_CAPTURE_EN
  logic       ff_valid;
  logic [3:0] ff_in0, ff_in1, ff_out;
  logic       fv_x0, fv_x1, fv_z;
  logic [7:0] fa_x0, fb_x0, fo_x0, fa_x1, fb_x1, fo_x1;
  logic [3:0] fa_z, fb_z, fo_z;
`endif

  logic_bist u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in0      (in0),
    .in1      (in1),
    .dut_out  (dut_out),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .all_pass (all_pass)
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    ,
    .ff_valid (ff_valid),
    .ff_in0   (ff_in0),
    .ff_in1   (ff_in1),
    .ff_out   (ff_out)
`endif
  );

  // XOR instances fed by a two-register pipeline.
  logic        start_x = 1'b0;
  logic        busy_x0, done_x0, ap_x0, busy_x1, done_x1, ap_x1;
  logic [7:0]  in0_x0, in1_x0, out_x0, in0_x1, in1_x1, out_x1;
  logic [7:0]  p1_x0, p2_x0, p1_x1, p2_x1;
  logic [15:0] pc_x0, fc_x0, pc_x1, fc_x1;

  always_ff @(posedge clk) begin
    p1_x0 <= in0_x0 ^ in1_x0;
    p2_x0 <= p1_x0;
    p1_x1 <= in0_x1 ^ in1_x1;
    p2_x1 <= p1_x1;
  end
  assign out_x0 = p2_x0;
  assign out_x1 = p2_x1;

  logic_bist #(.N(8), .OPCODE(2), .NUM_VEC(XNV), .WAIT_CYC(0)) u_x0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_x),
    .busy     (busy_x0),
    .done     (done_x0),
    .in0      (in0_x0),
    .in1      (in1_x0),
    .dut_out  (out_x0),
    .pass_cnt (pc_x0),
    .fail_cnt (fc_x0),
    .all_pass (ap_x0)
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    ,
    .ff_valid (fv_x0),
    .ff_in0   (fa_x0),
    .ff_in1   (fb_x0),
    .ff_out   (fo_x0)
`endif
  );

  logic_bist #(.N(8), .OPCODE(2), .NUM_VEC(XNV), .WAIT_CYC(1)) u_x1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_x),
    .busy     (busy_x1),
    .done     (done_x1),
    .in0      (in0_x1),
    .in1      (in1_x1),
    .dut_out  (out_x1),
    .pass_cnt (pc_x1),
    .fail_cnt (fc_x1),
    .all_pass (ap_x1)
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    ,
    .ff_valid (fv_x1),
    .ff_in0   (fa_x1),
    .ff_in1   (fb_x1),
    .ff_out   (fo_x1)
`endif
  );

  // Zero-vector instance.
  logic        start_z = 1'b0;
  logic        busy_z, done_z, ap_z;
  logic        seen_busy_z = 1'b0;
  logic [3:0]  in0_z, in1_z;
  logic [15:0] pc_z, fc_z;

  always @(posedge clk) if (busy_z === 1'b1) seen_busy_z <= 1'b1;

  logic_bist #(.NUM_VEC(0)) u_z (
    .clk      (clk),
    .rst      (rst),
    .start    (start_z),
    .busy     (busy_z),
    .done     (done_z),
    .in0      (in0_z),
    .in1      (in1_z),
    .dut_out  (in0_z | in1_z),
    .pass_cnt (pc_z),
    .fail_cnt (fc_z),
    .all_pass (ap_z)
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    ,
    .ff_valid (fv_z),
    .ff_in0   (fa_z),
    .ff_in1   (fb_z),
    .ff_out   (fo_z)
`endif
  );

  // Reference model: operand sequence generated from the feedback polynomial.
  logic [15:0] va[$], vb[$];
  logic [3:0]  qa[$], qb[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic gen_vectors(input int n);
    logic [15:0] s0, s1;
    s0 = 16'hACE1;
    s1 = 16'h1D2C;
    va.delete();
    vb.delete();
    for (int k = 0; k < n; k++) begin
      va.push_back(s0);
      vb.push_back(s1);
      s0 = lfsr_next(s0);
      s1 = lfsr_next(s1);
    end
  endtask

  task automatic do_run(input bit hold, output int cyc);
    qa.delete();
    qb.delete();
    cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (busy === 1'b1) begin
        qa.push_back(in0);
        qb.push_back(in1);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  function automatic int seq_errors();
    int e = 0;
    if (qa.size() != NV * (WC + 2)) return 1;
    for (int k = 0; k < NV; k++)
      for (int j = 0; j < WC + 2; j++)
        if (qa[k*(WC+2)+j] !== va[k][3:0] || qb[k*(WC+2)+j] !== vb[k][3:0]) e++;
    return e;
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (all_pass !== 1'b0) begin failures++; $display("FAIL reset_all_pass: got %b expected 0", all_pass); end
    checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", pass_cnt, fail_cnt); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in0 !== 4'h1 || in1 !== 4'hC) begin failures++; $display("FAIL reset_operands: got %h/%h expected 1/c", in0, in1); end
    checks++; if (in0_x0 !== 8'hE1 || in1_x0 !== 8'h2C) begin failures++; $display("FAIL reset_operands_n8: got %h/%h expected e1/2c", in0_x0, in1_x0); end
  endtask

  task automatic test_clean_run();
    int cyc;
    mode = 0;
    gen_vectors(NV);
    do_run(1'b0, cyc);
    checks++; if (cyc != NV * (WC + 2)) begin failures++; $display("FAIL clean_run_length: got %0d expected %0d", cyc, NV * (WC + 2)); end
    checks++; if (seq_errors() != 0) begin failures++; $display("FAIL clean_operand_seq: got %0d bad samples expected 0", seq_errors()); end
    checks++; if (pass_cnt !== 16'd100 || fail_cnt !== 16'd0) begin failures++; $display("FAIL clean_counts: got %0d/%0d expected 100/0", pass_cnt, fail_cnt); end
    checks++; if (all_pass !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL clean_flags: got all_pass=%b busy=%b expected 1/0", all_pass, busy); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || pass_cnt !== 16'd100 || all_pass !== 1'b1) begin failures++; $display("FAIL clean_hold: got done=%b pass=%0d all_pass=%b expected 1/100/1", done, pass_cnt, all_pass); end
  endtask

  task automatic test_random_faults();
    int cyc, ep, ef, first;
    logic [3:0] a, b, fo;
    gen_vectors(NV);
    for (int i = 0; i < 256; i++)
      corrupt_tbl[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    corrupt_tbl[{va[3][3:0], vb[3][3:0]}] = 4'b0100;
    ep = 0; ef = 0; first = -1; fo = 4'h0;
    for (int k = 0; k < NV; k++) begin
      a = va[k][3:0];
      b = vb[k][3:0];
      if (corrupt_tbl[{a, b}] == 4'h0) ep++;
      else begin
        ef++;
        if (first < 0) begin first = k; fo = (a | b) ^ corrupt_tbl[{a, b}]; end
      end
    end
    mode = 1;
    do_run(1'b0, cyc);
    mode = 0;
    checks++; if (cyc != NV * (WC + 2)) begin failures++; $display("FAIL random_run_length: got %0d expected %0d", cyc, NV * (WC + 2)); end
    checks++; if (pass_cnt !== 16'(ep) || fail_cnt !== 16'(ef)) begin failures++; $display("FAIL random_counts: got %0d/%0d expected %0d/%0d", pass_cnt, fail_cnt, ep, ef); end
    checks++; if (all_pass !== 1'b0) begin failures++; $display("FAIL random_all_pass: got %b expected 0", all_pass); end
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    checks++; if (ff_valid !== 1'b1 || ff_in0 !== va[first][3:0] || ff_in1 !== vb[first][3:0] || ff_out !== fo) begin
      failures++; $display("FAIL random_capture: got %b %h %h %h expected 1 %h %h %h", ff_valid, ff_in0, ff_in1, ff_out, va[first][3:0], vb[first][3:0], fo);
    end
`endif
  endtask

  task automatic test_stuck_bit();
    int cyc, ef, first;
    logic [3:0] r;
    gen_vectors(NV);
    ef = 0; first = -1;
    for (int k = 0; k < NV; k++) begin
      r = va[k][3:0] | vb[k][3:0];
      if (r[0]) begin ef++; if (first < 0) first = k; end
    end
    mode = 2;
    do_run(1'b0, cyc);
    mode = 0;
    checks++; if (fail_cnt !== 16'(ef) || fail_cnt == 16'd0) begin failures++; $display("FAIL stuck_fail_count: got %0d expected %0d", fail_cnt, ef); end
    checks++; if (pass_cnt + fail_cnt !== 16'd100) begin failures++; $display("FAIL stuck_total: got %0d expected 100", pass_cnt + fail_cnt); end
    checks++; if (all_pass !== 1'b0) begin failures++; $display("FAIL stuck_all_pass: got %b expected 0", all_pass); end
`ifdef LOGIC_BIST_ERR_CAPTURE_EN
    checks++; if (ff_valid !== 1'b1 || (ff_in0[0] | ff_in1[0]) !== 1'b1 || ff_in0 !== va[first][3:0]) begin
      failures++; $display("FAIL stuck_capture: got %b %h %h expected 1 %h %h", ff_valid, ff_in0, ff_in1, va[first][3:0], vb[first][3:0]);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    int cyc, seen_done, bad;
    mode = 0;
    gen_vectors(NV);
    qa.delete();
    qb.delete();
    seen_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) seen_done++;
      qa.push_back(in0);
      qb.push_back(in1);
      @(posedge clk); #1;
    end
    bad = 0;
    for (int i = 0; i < 50; i++)
      if (qa[i] !== va[i/(WC+2)][3:0] || qb[i] !== vb[i/(WC+2)][3:0]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL abort_prefix_seq: got %0d bad samples expected 0", bad); end
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== 16'd0 || in0 !== 4'h1 || in1 !== 4'hC) begin
      failures++; $display("FAIL async_reset: got busy=%b done=%b pass=%0d in=%h/%h expected 0/0/0/1/c", busy, done, pass_cnt, in0, in1);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    do_run(1'b0, cyc);
    checks++; if (seen_done != 0 || cyc != NV * (WC + 2)) begin failures++; $display("FAIL abort_no_done: got early=%0d len=%0d expected 0/%0d", seen_done, cyc, NV * (WC + 2)); end
    checks++; if (seq_errors() != 0) begin failures++; $display("FAIL restart_operand_seq: got %0d bad samples expected 0", seq_errors()); end
    checks++; if (pass_cnt !== 16'd100 || fail_cnt !== 16'd0 || all_pass !== 1'b1) begin failures++; $display("FAIL restart_counts: got %0d/%0d/%b expected 100/0/1", pass_cnt, fail_cnt, all_pass); end
  endtask

  task automatic test_back_to_back();
    int cyc, extra_busy;
    mode = 0;
    gen_vectors(NV);
    do_run(1'b1, cyc);
    checks++; if (cyc != NV * (WC + 2) || done !== 1'b1) begin failures++; $display("FAIL b2b_first_run: got len=%0d done=%b expected %0d/1", cyc, done, NV * (WC + 2)); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || in0 !== 4'h1) begin failures++; $display("FAIL b2b_restart: got busy=%b done=%b in0=%h expected 1/0/1", busy, done, in0); end
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (busy === 1'b1) cyc++;
      @(posedge clk); #1;
    end
    checks++; if (cyc != NV * (WC + 2)) begin failures++; $display("FAIL b2b_second_run: got %0d expected %0d", cyc, NV * (WC + 2)); end
    extra_busy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b1) extra_busy++;
    end
    checks++; if (extra_busy != 0) begin failures++; $display("FAIL b2b_single_run: got %0d extra busy cycles expected 0", extra_busy); end
  endtask

  task automatic test_xor_pipeline();
    int ef0, cyc;
    logic [7:0] prev, cur;
    gen_vectors(XNV);
    ef0 = 0;
    for (int k = 1; k < XNV; k++) begin
      prev = va[k-1][7:0] ^ vb[k-1][7:0];
      cur  = va[k][7:0] ^ vb[k][7:0];
      if (cur != prev) ef0++;
    end
    @(posedge clk); #1 start_x = 1'b1;
    @(posedge clk); #1 start_x = 1'b0;
    cyc = 0;
    while (!(done_x0 === 1'b1 && done_x1 === 1'b1) && cyc < 1000) begin
      cyc++;
      @(posedge clk); #1;
    end
    checks++; if (cyc >= 1000) begin failures++; $display("FAIL xor_timeout: got %0d cycles expected done", cyc); end
    checks++; if (fc_x0 !== 16'(ef0) || fc_x0 == 16'd0 || pc_x0 + fc_x0 !== 16'(XNV)) begin
      failures++; $display("FAIL xor_wait0_counts: got %0d/%0d expected %0d/%0d", pc_x0, fc_x0, XNV - ef0, ef0);
    end
    checks++; if (ap_x0 !== 1'b0) begin failures++; $display("FAIL xor_wait0_all_pass: got %b expected 0", ap_x0); end
    checks++; if (pc_x1 !== 16'(XNV) || fc_x1 !== 16'd0 || ap_x1 !== 1'b1) begin
      failures++; $display("FAIL xor_wait1_counts: got %0d/%0d/%b expected %0d/0/1", pc_x1, fc_x1, ap_x1, XNV);
    end
  endtask

  task automatic test_zero_vectors();
    @(posedge clk); #1 start_z = 1'b1;
    @(posedge clk); #1 start_z = 1'b0;
    checks++; if (done_z !== 1'b1 || ap_z !== 1'b1) begin failures++; $display("FAIL zero_done: got done=%b all_pass=%b expected 1/1", done_z, ap_z); end
    checks++; if (pc_z !== 16'd0 || fc_z !== 16'd0) begin failures++; $display("FAIL zero_counts: got %0d/%0d expected 0/0", pc_z, fc_z); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (seen_busy_z !== 1'b0 || busy_z !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b expected 0", seen_busy_z); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_random_faults();
    test_stuck_bit();
    test_reset_mid_run();
    test_back_to_back();
    test_xor_pipeline();
    test_zero_vectors();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
